// File: rtl/multi_ported_sram_pkg.sv
// Shared types and helpers for the LVT multi-ported SRAM write scheduler.
package multi_ported_sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Number of cycles one initialisation sweep occupies the write ports.
  function automatic int unsigned sweep_cycles(input int unsigned n, input int unsigned nw);
    return (n + nw - 1) / nw;
  endfunction

endpackage

// File: rtl/multi_ported_sram_wr_sched_if.sv
// Requester handshake plus SRAM write-port bus of the write scheduler.
interface multi_ported_sram_wr_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_W   = 2,
  parameter int unsigned W       = 32,
  parameter int unsigned ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*W-1:0]      req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      init;
  logic                      busy_w;
  logic [NUM_W-1:0]          wen;
  logic [NUM_W*ADDR_W-1:0]   waddr;
  logic [NUM_W*W-1:0]        wdata;

  modport master (
    output req_valid, req_addr, req_data, init,
    input  req_ready, busy_w, wen, waddr, wdata
  );

  modport slave (
    input  req_valid, req_addr, req_data, init,
    output req_ready, busy_w, wen, waddr, wdata
  );
endinterface

// File: rtl/multi_ported_sram_wr_pick.sv
// Combinational round-robin picker: scans from ptr, grants up to NUM_W
// requesters with pairwise distinct addresses, maps the j-th grant to port j.
module multi_ported_sram_wr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_W   = 2,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0]        valid,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [PTR_W-1:0]          ptr,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_W*PTR_W-1:0]    port_idx,
  output logic [NUM_W-1:0]          port_vld,
  output logic [PTR_W-1:0]          ptr_nxt
);

  logic [NUM_W*ADDR_W-1:0] gaddr;

  always_comb begin
    int unsigned     idx;
    int unsigned     n_gnt;
    logic            hit;
    logic [ADDR_W-1:0] cur;
    grant    = '0;
    port_idx = '0;
    port_vld = '0;
    gaddr    = '0;
    ptr_nxt  = ptr;
    n_gnt    = 0;
    for (int unsigned s = 0; s < NUM_REQ; s++) begin
      idx = 32'(ptr) + s;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cur = addr[idx*ADDR_W +: ADDR_W];
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_W; k++) begin
        if (k < n_gnt && gaddr[k*ADDR_W +: ADDR_W] == cur) hit = 1'b1;
      end
      // A conflicting requester is skipped without consuming a port.
      if (valid[idx] && n_gnt < NUM_W && !hit) begin
        grant[idx]                       = 1'b1;
        port_idx[n_gnt*PTR_W +: PTR_W]   = PTR_W'(idx);
        gaddr[n_gnt*ADDR_W +: ADDR_W]    = cur;
        port_vld[n_gnt]                  = 1'b1;
        n_gnt                            = n_gnt + 1;
        ptr_nxt = (idx + 1 == NUM_REQ) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/multi_ported_sram_wr_sched.sv
// Write scheduler/initialiser for the LVT multi-ported SRAM: INIT sweeps
// INIT_VAL into every entry, IDLE arbitrates requesters onto write ports.
module multi_ported_sram_wr_sched
  import multi_ported_sram_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_W    = 2,
  parameter int unsigned W        = 32,
  parameter int unsigned N        = 8,
  parameter logic [W-1:0] INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  multi_ported_sram_wr_sched_if.slave bus
);

  localparam int unsigned ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t                  state_q, state_d;
  logic [ADDR_W:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic [NUM_W-1:0]        wen_q, wen_d;
  logic [NUM_W*ADDR_W-1:0] waddr_q, waddr_d;
  logic [NUM_W*W-1:0]      wdata_q, wdata_d;

  logic [NUM_REQ-1:0]      grant;
  logic [NUM_W*PTR_W-1:0]  port_idx;
  logic [NUM_W-1:0]        port_vld;
  logic [PTR_W-1:0]        ptr_nxt;

  multi_ported_sram_wr_pick #(
    .NUM_REQ (NUM_REQ),
    .NUM_W   (NUM_W),
    .ADDR_W  (ADDR_W),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid    (bus.req_valid),
    .addr     (bus.req_addr),
    .ptr      (ptr_q),
    .grant    (grant),
    .port_idx (port_idx),
    .port_vld (port_vld),
    .ptr_nxt  (ptr_nxt)
  );

  always_comb begin
    int unsigned       a;
    logic [PTR_W-1:0]  sel;
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    wen_d   = '0;
    waddr_d = '0;
    wdata_d = '0;
    a       = 0;
    sel     = '0;
    if (state_q == ST_INIT) begin
      for (int unsigned k = 0; k < NUM_W; k++) begin
        a = 32'(cnt_q) + k;
        wen_d[k]                     = (a < N);
        waddr_d[k*ADDR_W +: ADDR_W]  = a[ADDR_W-1:0];
        wdata_d[k*W +: W]            = INIT_VAL;
      end
      a     = 32'(cnt_q) + NUM_W;
      cnt_d = (ADDR_W+1)'(a);
      if (a >= N) state_d = ST_IDLE;
    end else begin
      for (int unsigned k = 0; k < NUM_W; k++) begin
        if (port_vld[k]) begin
          sel                          = port_idx[k*PTR_W +: PTR_W];
          wen_d[k]                     = 1'b1;
          waddr_d[k*ADDR_W +: ADDR_W]  = bus.req_addr[sel*ADDR_W +: ADDR_W];
          wdata_d[k*W +: W]            = bus.req_data[sel*W +: W];
        end
      end
      ptr_d = ptr_nxt;
      // This cycle's grants still land; the sweep starts on the next cycle.
      if (bus.init) begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    end
    busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign bus.busy_w    = busy_q;
  assign bus.wen       = wen_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;

endmodule

// File: tb/tb_multi_ported_sram_wr_sched.sv
// Directed bench for multi_ported_sram_wr_sched: main 4x2/N=8 instance plus a
// NUM_W=4/N=6 instance for the partial final sweep step.
module tb_multi_ported_sram_wr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  multi_ported_sram_wr_sched_if #(.NUM_REQ(4), .NUM_W(2), .W(32), .ADDR_W(3)) bus_a ();
  multi_ported_sram_wr_sched_if #(.NUM_REQ(2), .NUM_W(4), .W(32), .ADDR_W(3)) bus_b ();

  multi_ported_sram_wr_sched #(
    .NUM_REQ(4), .NUM_W(2), .W(32), .N(8), .INIT_VAL(32'h0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  multi_ported_sram_wr_sched #(
    .NUM_REQ(2), .NUM_W(4), .W(32), .N(6), .INIT_VAL(32'h0)
  ) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [2:0] a, input logic [31:0] d);
    bus_a.req_valid[i]       = v;
    bus_a.req_addr[i*3 +: 3] = a;
    bus_a.req_data[i*32 +: 32] = d;
  endtask

  // One sweep step on the main instance: ports carry {base+1, base}, data 0.
  task automatic chk_sweep(input string tag, input logic [2:0] base, input logic busy);
    logic [2:0] hi;
    hi = base + 3'd1;
    check_eq({tag, "_wen"},   64'(bus_a.wen),    64'(2'b11));
    check_eq({tag, "_waddr"}, 64'(bus_a.waddr),  64'({hi, base}));
    check_eq({tag, "_wdata"}, 64'(bus_a.wdata),  64'h0);
    check_eq({tag, "_busy"},  64'(bus_a.busy_w), 64'(busy));
    check_eq({tag, "_rdy"},   64'(bus_a.req_ready), 64'h0);
  endtask

  initial begin
    bus_a.req_valid = '0; bus_a.req_addr = '0; bus_a.req_data = '0; bus_a.init = 1'b0;
    bus_b.req_valid = '0; bus_b.req_addr = '0; bus_b.req_data = '0; bus_b.init = 1'b0;

    // Reset held for two cycles.
    step();
    check_eq("rst_wen",   64'(bus_a.wen),    64'h0);
    check_eq("rst_busy",  64'(bus_a.busy_w), 64'h1);
    step();
    check_eq("rst_waddr", 64'(bus_a.waddr),  64'h0);
    check_eq("rst_wdata", 64'(bus_a.wdata),  64'h0);
    check_eq("rst_rdy",   64'(bus_a.req_ready), 64'h0);
    rst = 1'b0;
    check_eq("c0_wen",  64'(bus_a.wen),    64'h0);
    check_eq("c0_busy", 64'(bus_a.busy_w), 64'h1);

    // Reset sweep; the N=6/NUM_W=4 instance finishes in two steps.
    step();
    chk_sweep("sw0", 3'd0, 1'b1);
    check_eq("p6_wen0",   64'(bus_b.wen),    64'(4'b1111));
    check_eq("p6_addr0",  64'(bus_b.waddr),  64'({3'd3, 3'd2, 3'd1, 3'd0}));
    check_eq("p6_busy0",  64'(bus_b.busy_w), 64'h1);
    step();
    chk_sweep("sw1", 3'd2, 1'b1);
    check_eq("p6_wen1",   64'(bus_b.wen),    64'(4'b0011));
    check_eq("p6_addr1",  64'(bus_b.waddr[5:0]), 64'({3'd5, 3'd4}));
    check_eq("p6_busy1",  64'(bus_b.busy_w), 64'h0);
    step();
    chk_sweep("sw2", 3'd4, 1'b1);
    step();
    chk_sweep("sw3", 3'd6, 1'b0);

    // Round-robin: four requesters, addrs 1..4.
    for (int unsigned i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i + 1), 32'hA0 + i);
    #1 check_eq("rr0_rdy", 64'(bus_a.req_ready), 64'(4'b0011));
    step();
    check_eq("rr0_wen",   64'(bus_a.wen),   64'(2'b11));
    check_eq("rr0_waddr", 64'(bus_a.waddr), 64'({3'd2, 3'd1}));
    check_eq("rr0_wdata", 64'(bus_a.wdata), {32'hA1, 32'hA0});
    check_eq("rr1_rdy",   64'(bus_a.req_ready), 64'(4'b1100));
    step();
    check_eq("rr1_waddr", 64'(bus_a.waddr), 64'({3'd4, 3'd3}));
    check_eq("rr1_wdata", 64'(bus_a.wdata), {32'hA3, 32'hA2});
    check_eq("rr2_rdy",   64'(bus_a.req_ready), 64'(4'b0011));

    // Same-address conflict with ptr=0: req1 deferred.
    set_req(0, 1'b1, 3'd5, 32'hB0);
    set_req(1, 1'b1, 3'd5, 32'hB1);
    set_req(2, 1'b1, 3'd6, 32'hB2);
    set_req(3, 1'b0, 3'd0, 32'h0);
    #1 check_eq("cf_rdy", 64'(bus_a.req_ready), 64'(4'b0101));
    step();
    check_eq("cf_wen",   64'(bus_a.wen),   64'(2'b11));
    check_eq("cf_waddr", 64'(bus_a.waddr), 64'({3'd6, 3'd5}));
    check_eq("cf_wdata", 64'(bus_a.wdata), {32'hB2, 32'hB0});
    // ptr is now 3: scan 3,0 wins over 1,2.
    set_req(0, 1'b1, 3'd7, 32'hC0);
    set_req(3, 1'b1, 3'd0, 32'hC3);
    #1 check_eq("ptr3_rdy", 64'(bus_a.req_ready), 64'(4'b1001));
    step();
    check_eq("ptr3_waddr", 64'(bus_a.waddr), 64'({3'd7, 3'd0}));
    check_eq("ptr3_wdata", 64'(bus_a.wdata), {32'hC0, 32'hC3});
    check_eq("late_rdy",   64'(bus_a.req_ready), 64'(4'b0110));
    step();
    check_eq("late_waddr", 64'(bus_a.waddr), 64'({3'd6, 3'd5}));
    check_eq("late_wdata", 64'(bus_a.wdata), {32'hB2, 32'hB1});

    // init mid-traffic: req0 handshake and init in the same cycle.
    bus_a.req_valid = '0;
    set_req(0, 1'b1, 3'd0, 32'hDEADBEEF);
    bus_a.init = 1'b1;
    #1 check_eq("ini_rdy",  64'(bus_a.req_ready), 64'(4'b0001));
    check_eq("ini_busy0", 64'(bus_a.busy_w), 64'h0);
    step();
    bus_a.init = 1'b0;
    check_eq("ini_wen",   64'(bus_a.wen),   64'(2'b01));
    check_eq("ini_waddr", 64'(bus_a.waddr[2:0]), 64'h0);
    check_eq("ini_wdata", 64'(bus_a.wdata[31:0]), 64'hDEADBEEF);
    check_eq("ini_busy1", 64'(bus_a.busy_w), 64'h1);
    bus_a.req_valid = 4'b1111;
    #1 check_eq("ini_rdy_blk", 64'(bus_a.req_ready), 64'h0);
    bus_a.req_valid = '0;
    step();
    chk_sweep("isw0", 3'd0, 1'b1);
    bus_a.init = 1'b1;
    step();
    bus_a.init = 1'b0;
    chk_sweep("isw1", 3'd2, 1'b1);
    step();
    chk_sweep("isw2", 3'd4, 1'b1);
    step();
    chk_sweep("isw3", 3'd6, 1'b0);

    // rst during the second output cycle of a fresh sweep.
    bus_a.init = 1'b1;
    step();
    bus_a.init = 1'b0;
    check_eq("rs_busy", 64'(bus_a.busy_w), 64'h1);
    check_eq("rs_wen",  64'(bus_a.wen),    64'h0);
    step();
    chk_sweep("rs_sw0", 3'd0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rs_clr_wen",   64'(bus_a.wen),   64'h0);
    check_eq("rs_clr_waddr", 64'(bus_a.waddr), 64'h0);
    check_eq("rs_clr_busy",  64'(bus_a.busy_w), 64'h1);
    step();
    chk_sweep("rs_sw0b", 3'd0, 1'b1);
    step();
    chk_sweep("rs_sw1b", 3'd2, 1'b1);
    step();
    chk_sweep("rs_sw2b", 3'd4, 1'b1);
    step();
    chk_sweep("rs_sw3b", 3'd6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ported_sram_wr_sched.md
# multi_ported_sram_wr_sched

Write scheduler and initialiser for the LVT multi-ported SRAM. It arbitrates NUM_REQ write requesters onto the NUM_W write ports with a round-robin policy. It never issues two writes to the same address in one cycle, because that would corrupt the live-value table. It also sweeps INIT_VAL into every entry after reset or on request, and drives busy_w while doing so. It sits directly in front of the SRAM's `wen`/`waddr`/`wdata`/`init` inputs.

## Interface
- NUM_REQ, 4, number of write requesters (≥1)
- NUM_W, 2, SRAM write ports (≥1; ports beyond NUM_REQ stay idle)
- W, 32, data width
- N, 8, SRAM entries; ADDR_W = $clog2(N)
- INIT_VAL, '0, W-bit value written by the sweep
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  request per requester
- req_addr  in  NUM_REQ*ADDR_W  flattened address, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*W  flattened write data
- req_ready  out  NUM_REQ  grant; the handshake completes on valid&ready
- init  in  1  request a fresh sweep
- busy_w  out  1  sweep in progress; registered
- wen  out  NUM_W  registered SRAM write enables
- waddr  out  NUM_W*ADDR_W  registered, flattened
- wdata  out  NUM_W*W  registered, flattened

## Operation
- The FSM has two states, INIT and IDLE. Reset puts it in INIT with sweep counter cnt=0 and rr pointer ptr=0.
- **INIT:**
  - req_ready is all 0.
  - Each cycle, port k writes address cnt+k with data INIT_VAL. Its wen bit is set only if cnt+k < N.
  - cnt advances by NUM_W. cnt is ADDR_W+1 bits, so it does not wrap when N is a power of two.
  - When cnt+NUM_W ≥ N, the FSM moves to IDLE on the next cycle.
  - init is ignored while in INIT.
- **IDLE:**
  - The picker scans requesters starting at ptr, ascending modulo NUM_REQ.
  - Requester i is granted if it is valid, fewer than NUM_W grants have been made this cycle, and its addr differs from every address already granted this cycle.
  - A conflicting requester is deferred without consuming a port.
  - The j-th grant in scan order maps to port j. Unused ports get wen=0.
  - req_ready is combinational from req_valid, req_addr and ptr.
  - If any grant was made, ptr becomes (last granted index + 1) mod NUM_REQ; otherwise ptr is unchanged.
- **init in IDLE:** this cycle's grants still complete. The FSM enters INIT on the next cycle with cnt=0.
- **Arithmetic:** all address compares are on the full ADDR_W bits. Out-of-range request addresses (≥N) are passed through unchecked.

## Timing
- **Reset values** (during rst and on the first cycle after it):
  - wen=0, waddr=0, wdata=0
  - busy_w=1
  - req_ready=0
- **Write latency:** a handshake at cycle T appears on wen/waddr/wdata at T+1. A sweep step in INIT at cycle t appears at t+1.
- **busy_w:** equals (state==INIT), registered. It deasserts in the same cycle the last sweep write is on the outputs. req_ready can rise that cycle, and the resulting writes land one cycle later, so they are strictly after the sweep.
- **Sweep length:** ceil(N/NUM_W) cycles.
- **Handshake at T with init at T:** the write lands at T+1 and is overwritten by the sweep starting at T+2.
- **rst mid-sweep:** the sweep restarts from cnt=0 and the outputs clear.
- **Read-after-write:** there is no bypass. Consumers must not read an address until 2 cycles after its handshake.

## Structure
- **Shared package** multi_ported_sram_pkg.svh gets:
  - the state enum type (INIT, IDLE)
  - a function returning the sweep cycle count for (N, NUM_W)
- **Sub-module** multi_ported_sram_wr_pick: combinational rotate/scan/conflict picker.
  - Inputs: valid, addr, ptr.
  - Outputs: grant vector, per-port requester index, per-port valid, next ptr.
- **Top level** holds the FSM, cnt, ptr and the output registers.

## Test plan
All scenarios use NUM_REQ=4, NUM_W=2, N=8, W=32, INIT_VAL=0 unless noted.
1. **Reset sweep:** assert rst for 2 cycles, then release. Expect wen=11 with waddr pairs {0,1},{2,3},{4,5},{6,7} on 4 consecutive cycles, data 0. busy_w=1 until the cycle carrying {6,7}, then 0. req_ready=0 throughout.
2. **Round-robin:** all 4 valid with addrs 1,2,3,4 held. Expect grants {0,1} then {2,3} then {0,1}. Port 0 carries the lower scan index. Writes appear 1 cycle after each grant.
3. **Same-address conflict:** ptr=0, req0 and req1 both at addr 5, req2 at addr 6. Expect req_ready=0101, port0=(5,data0), port1=(6,data2), and ptr becomes 3 next cycle. req1 is granted on a later cycle.
4. **init mid-traffic:** pulse init at T with req0 valid. Expect req0 written at T+1, busy_w=1 from T+1, the sweep on outputs T+2..T+5, and addr 0 finally holding 0.
5. **Partial last sweep step** (NUM_W=4, N=6): expect wen=1111 at addrs 0–3, then wen=0011 at addrs 4,5 (ports 2–3 idle). busy_w falls on the second cycle.
6. **rst mid-sweep:** assert rst during the 2nd sweep cycle. Expect outputs cleared and the sweep restarting at addrs {0,1} after release.
